// File: rtl/adpll_cfg_sequencer.sv
// ADPLL parameter-programming initiator: holds a small host-loaded table and
// replays it into the ADPLL as setup / pgm pulse / hold sequences, with an
// optional leading clr phase. All outputs come straight from flops.
module adpll_cfg_sequencer #(
  parameter int NUM_PARAMS = 6,
  parameter int SEL_W      = 3,
  parameter int VAL_W      = 5,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int CLR_CYC    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tbl_we,
  input  logic [SEL_W-1:0] tbl_addr,
  input  logic [VAL_W-1:0] tbl_wdata,
  input  logic             start,
  input  logic             do_clr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             wr_err,
  output logic             clr,
  output logic             pgm,
  output logic [SEL_W-1:0] param_sel,
  output logic [VAL_W-1:0] pgm_value
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0]    C_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0]    C_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0]    C_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]    C_CLR   = CW'(CLR_CYC - 1);
  localparam logic [SEL_W:0]   NP      = (SEL_W+1)'(NUM_PARAMS);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(NUM_PARAMS - 1);

  logic [2:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SEL_W-1:0] idx, idx_nxt;
  logic [NUM_PARAMS-1:0][VAL_W-1:0] tbl;
  logic             wr_ok;
  logic [VAL_W-1:0] rd_val;

  assign wr_ok = tbl_we && (state == S_IDLE) && ({1'b0, tbl_addr} < NP);

  // A write landing on the same edge as start must reach the first SETUP,
  // so forward it around the table.
  assign rd_val = (wr_ok && (tbl_addr == idx_nxt)) ? tbl_wdata : tbl[idx_nxt];

  // Next-state / counter / index; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    case (state)
      S_IDLE: if (start) begin
        idx_nxt = '0;
        if (do_clr) begin state_nxt = S_CLR;   cnt_nxt = C_CLR;   end
        else        begin state_nxt = S_SETUP; cnt_nxt = C_SETUP; end
      end
      S_CLR: if (cnt == '0) begin
        state_nxt = S_SETUP; cnt_nxt = C_SETUP; idx_nxt = '0;
      end else cnt_nxt = cnt - 1'b1;
      S_SETUP: if (cnt == '0) begin
        state_nxt = S_PULSE; cnt_nxt = C_PULSE;
      end else cnt_nxt = cnt - 1'b1;
      S_PULSE: if (cnt == '0) begin
        state_nxt = S_HOLD; cnt_nxt = C_HOLD;
      end else cnt_nxt = cnt - 1'b1;
      S_HOLD: if (cnt == '0) begin
        if (idx == LAST) begin
          state_nxt = S_DONE; cnt_nxt = '0;
        end else begin
          state_nxt = S_SETUP; cnt_nxt = C_SETUP; idx_nxt = idx + 1'b1;
        end
      end else cnt_nxt = cnt - 1'b1;
      S_DONE: begin state_nxt = S_IDLE; idx_nxt = '0; end
      default: begin state_nxt = S_IDLE; cnt_nxt = '0; idx_nxt = '0; end
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Parameter table; only written while idle, so a run sees a fixed snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tbl <= '0;
    else if (wr_ok) tbl[tbl_addr] <= tbl_wdata;
  end

  // Outputs decoded from the next state so they change with the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      clr       <= 1'b0;
      pgm       <= 1'b0;
      param_sel <= '0;
      pgm_value <= '0;
    end else begin
      busy   <= (state_nxt != S_IDLE);
      done   <= (state_nxt == S_DONE);
      wr_err <= tbl_we && !wr_ok;
      clr    <= (state_nxt == S_CLR);
      pgm    <= (state_nxt == S_PULSE);
      // Bus only moves on SETUP entry, while pgm is already low.
      if ((state_nxt == S_SETUP) && (state != S_SETUP)) begin
        param_sel <= idx_nxt;
        pgm_value <= rd_val;
      end else if ((state_nxt == S_IDLE) || (state_nxt == S_CLR)) begin
        param_sel <= '0;
        pgm_value <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adpll_cfg_sequencer.sv
// Directed bench for adpll_cfg_sequencer: table-write vectors plus per-cycle
// checks of full, aborted and reset-interrupted programming runs.
module tb_adpll_cfg_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       tbl_we = 1'b0, start = 1'b0, do_clr = 1'b0, abort = 1'b0;
  logic [2:0] tbl_addr = '0;
  logic [4:0] tbl_wdata = '0;
  logic       busy, done, wr_err, clr, pgm;
  logic [2:0] param_sel;
  logic [4:0] pgm_value;
  int checks = 0, errors = 0;

  adpll_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .start(start), .do_clr(do_clr), .abort(abort),
    .busy(busy), .done(done), .wr_err(wr_err), .clr(clr), .pgm(pgm),
    .param_sel(param_sel), .pgm_value(pgm_value)
  );

  always #5 clk = ~clk;

  // busy12 done11 wr_err10 clr9 pgm8 sel7:5 val4:0
  logic [12:0] ov;
  assign ov = {busy, done, wr_err, clr, pgm, param_sel, pgm_value};

  typedef struct {
    logic [2:0] addr;
    logic [4:0] data;
    logic       exp_err;
  } wr_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one programming sequence and checks every cycle against the
  // setup/pulse/hold positional timing. abort_at>0 aborts after that cycle.
  task automatic run_check(input bit dc, input logic [5:0][4:0] ev, input int abort_at,
                           input bit wr, input logic [2:0] wa, input logic [4:0] wd);
    int n;
    int u;
    logic [12:0] e, m;
    n = (dc ? 4 : 0) + 37;
    start = 1'b1; do_clr = dc;
    if (wr) begin tbl_we = 1'b1; tbl_addr = wa; tbl_wdata = wd; end
    step;
    start = 1'b0; do_clr = 1'b0; tbl_we = 1'b0;
    for (int t = 1; t <= n + 1; t++) begin
      e = '0; m = '1;
      if (t <= n) e[12] = 1'b1;
      if (dc && t <= 4) e[9] = 1'b1;
      else if (t < n) begin
        u = t - (dc ? 4 : 0) - 1;
        e[7:5] = 3'(u / 6);
        e[4:0] = ev[u / 6];
        e[8]   = (u % 6 == 2) || (u % 6 == 3);
      end else if (t == n) begin
        e[11] = 1'b1;
        m[7:0] = '0;
      end
      chk($sformatf("run dc=%0d t=%0d", dc, t), 32'(ov & m), 32'(e & m));
      if (t == abort_at) begin
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("abort outputs", 32'(ov), 32'h0);
        for (int k = 0; k < 5; k++) begin
          step;
          chk("abort no done", 32'(done), 32'h0);
        end
        return;
      end
      step;
    end
  endtask

  initial begin
    wr_vec_t vecs[8];
    logic [5:0][4:0] exp1, exp0;
    for (int i = 0; i < 6; i++) begin
      vecs[i] = '{addr: 3'(i), data: 5'(i + 1), exp_err: 1'b0};
      exp1[i] = 5'(i + 1);
      exp0[i] = 5'd0;
    end
    vecs[6] = '{addr: 3'd6, data: 5'd17, exp_err: 1'b1};
    vecs[7] = '{addr: 3'd7, data: 5'd30, exp_err: 1'b1};

    // T1: reset state and table load
    #12;
    chk("reset outputs", 32'(ov), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step;
    chk("post reset outputs", 32'(ov), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tbl_we = 1'b1; tbl_addr = vecs[i].addr; tbl_wdata = vecs[i].data;
      step;
      tbl_we = 1'b0;
      chk($sformatf("wr_err addr=%0d", vecs[i].addr), 32'(wr_err), 32'(vecs[i].exp_err));
    end
    step;
    chk("wr_err clears", 32'(wr_err), 32'h0);

    // T2 / T3: full runs with and without clear
    run_check(1'b1, exp1, 0, 1'b0, 3'd0, 5'd0);
    run_check(1'b0, exp1, 0, 1'b0, 3'd0, 5'd0);

    // T4: write while busy is rejected
    start = 1'b1; step; start = 1'b0;
    step; step;
    tbl_we = 1'b1; tbl_addr = 3'd0; tbl_wdata = 5'd31;
    step;
    tbl_we = 1'b0;
    chk("busy write wr_err", 32'(wr_err), 32'h1);
    chk("busy during write", 32'(busy), 32'h1);
    step;
    chk("busy write wr_err pulse", 32'(wr_err), 32'h0);
    for (int i = 0; i < 100 && busy; i++) step;
    chk("t4 run ends", 32'(busy), 32'h0);
    step;

    // T5: abort during third pulse, then a clean replay
    run_check(1'b0, exp1, 15, 1'b0, 3'd0, 5'd0);
    run_check(1'b0, exp1, 0, 1'b0, 3'd0, 5'd0);

    // T6: async reset mid-HOLD clears outputs and table
    start = 1'b1; step; start = 1'b0;
    step; step; step; step;
    chk("pre-reset hold", 32'({busy, pgm, pgm_value}), 32'({1'b1, 1'b0, 5'd1}));
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", 32'(ov), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step;
    run_check(1'b0, exp0, 0, 1'b0, 3'd0, 5'd0);

    // start with simultaneous write: run sees the new value
    exp0[0] = 5'd9;
    run_check(1'b0, exp0, 0, 1'b1, 3'd0, 5'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
